// File: rtl/mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// mult_share_arbiter
//
// Shares one W x W unsigned sequential multiplier among N_REQ requesters.
// A requester raises req[i] with its operands and holds them until gnt[i].
// The arbiter then:
//   - latches the operands,
//   - pulses mul_load,
//   - waits MUL_LAT cycles,
//   - captures mul_product,
//   - returns the product with the requester index on a valid/ready handshake.
//
// Configuration macro:
//   MULT_ARB_RR_EN  defined   -> round-robin arbitration. The search starts
//                                one past the last winner.
//                   undefined -> fixed priority. The lowest index wins.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   req             per-requester request
//   req_a, req_b    packed operands, requester i at [i*W +: W]
//   gnt             one-hot, single-cycle grant (combinational in IDLE)
//   resp_valid      result available (registered)
//   resp_ready      consumer accepts result
//   resp_id         index of the requester that owns the result
//   resp_product    full-width unsigned product a*b
//   busy            high whenever the arbiter is not idle
//   mul_load        load pulse to the shared multiplier
//   mul_a, mul_b    operands held on the multiplier inputs
//   mul_product     multiplier result
// -----------------------------------------------------------------------------
module mult_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 6,
    parameter int MUL_LAT = 6,
    localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*W-1:0]   req_a,
    input  logic [N_REQ*W-1:0]   req_b,
    output logic [N_REQ-1:0]     gnt,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [2*W-1:0]       resp_product,
    output logic                 busy,
    output logic                 mul_load,
    output logic [W-1:0]         mul_a,
    output logic [W-1:0]         mul_b,
    input  logic [2*W-1:0]       mul_product
);

    localparam int CW = $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CW-1:0]      cnt_r;
    logic [IDW-1:0]     id_r;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic [2*W-1:0]     prod_r;
    logic               busy_r;
    logic               mul_load_r;
    logic               resp_valid_r;

    logic               grant_s;
    logic [IDW-1:0]     win_s;
    logic [N_REQ-1:0]   gnt_s;
    logic [W-1:0]       op_a_s;
    logic [W-1:0]       op_b_s;

`ifdef MULT_ARB_RR_EN
    logic [IDW-1:0]     rr_ptr_r;

    // Round robin: pick the requester closest after ptr, wrapping modulo N_REQ.
    function automatic logic [IDW-1:0] pick_rr(input logic [N_REQ-1:0] r,
                                               input logic [IDW-1:0]   ptr);
        logic [IDW-1:0] w;
        int             best;
        int             dist;
        logic           take;
        w    = {IDW{1'b0}};
        best = N_REQ;
        for (int j = 0; j < N_REQ; j++) begin
            dist = (j - int'(ptr) - 1 + 2 * N_REQ) % N_REQ;
            take = r[j] && (dist < best);
            w    = take ? IDW'(j) : w;
            best = take ? dist : best;
        end
        return w;
    endfunction
`else
    // Fixed priority: the lowest asserted index wins.
    function automatic logic [IDW-1:0] pick_fixed(input logic [N_REQ-1:0] r);
        logic [IDW-1:0] w;
        w = {IDW{1'b0}};
        for (int j = N_REQ - 1; j >= 0; j--) begin
            w = r[j] ? IDW'(j) : w;
        end
        return w;
    endfunction
`endif

    // Arbitration winner and a mux of that requester's operands.
    always_comb begin
        op_a_s = {W{1'b0}};
        op_b_s = {W{1'b0}};
`ifdef MULT_ARB_RR_EN
        win_s = pick_rr(req, rr_ptr_r);
`else
        win_s = pick_fixed(req);
`endif
        for (int i = 0; i < N_REQ; i++) begin
            op_a_s = (win_s == IDW'(i)) ? req_a[i*W +: W] : op_a_s;
            op_b_s = (win_s == IDW'(i)) ? req_b[i*W +: W] : op_b_s;
        end
    end

    // Next-state logic and the combinational grant.
    // A grant is suppressed while rst is high, so no requester sees a grant
    // for an operation that the reset discards.
    always_comb begin
        state_s = state_r;
        grant_s = 1'b0;
        gnt_s   = {N_REQ{1'b0}};
        case (state_r)
            S_IDLE: begin
                if ((|req) && !rst) begin
                    grant_s = 1'b1;
                    gnt_s   = {{(N_REQ-1){1'b0}}, 1'b1} << win_s;
                    state_s = S_ISSUE;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_s = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_r == CW'(MUL_LAT)) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_DONE: begin
                // resp_valid is high throughout DONE, so ready alone completes the handshake.
                if (resp_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State register, operand latch, latency counter and registered outputs.
    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            cnt_r        <= {CW{1'b0}};
            id_r         <= {IDW{1'b0}};
            a_r          <= {W{1'b0}};
            b_r          <= {W{1'b0}};
            prod_r       <= {(2*W){1'b0}};
            busy_r       <= 1'b0;
            mul_load_r   <= 1'b0;
            resp_valid_r <= 1'b0;
`ifdef MULT_ARB_RR_EN
            rr_ptr_r     <= IDW'(N_REQ - 1);
`endif
        end else begin
            state_r      <= state_s;
            busy_r       <= (state_s != S_IDLE);
            mul_load_r   <= (state_s == S_ISSUE);
            resp_valid_r <= (state_s == S_DONE);
            if (grant_s) begin
                id_r     <= win_s;
                a_r      <= op_a_s;
                b_r      <= op_b_s;
`ifdef MULT_ARB_RR_EN
                rr_ptr_r <= win_s;
`endif
            end
            if (state_r == S_ISSUE) begin
                cnt_r <= CW'(1);
            end else if (state_r == S_WAIT) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= {CW{1'b0}};
            end
            // The product is stable in the last WAIT cycle; capture it as DONE begins.
            if ((state_r == S_WAIT) && (cnt_r == CW'(MUL_LAT))) begin
                prod_r <= mul_product;
            end
        end
    end

    assign gnt          = gnt_s;
    assign resp_valid   = resp_valid_r;
    assign resp_id      = id_r;
    assign resp_product = prod_r;
    assign busy         = busy_r;
    assign mul_load     = mul_load_r;
    assign mul_a        = a_r;
    assign mul_b        = b_r;

endmodule
